// File: rtl/bcd_to_binary.sv
// rtl/bcd_to_binary.sv - sequential reverse double-dabble BCD (4 digits) to binary converter
module bcd_to_binary #(
  parameter int NUM_BITS = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         bcd_in,
  input  logic                bcd_in_valid,
  output logic                bcd_in_ready,
  output logic [NUM_BITS-1:0] binary_out,
  output logic                binary_out_valid,
  input  logic                binary_out_ready,
  output logic                bcd_error
);

  localparam int CW = $clog2(NUM_BITS + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(NUM_BITS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    ADJUST = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                    state;
  logic [15:0]               bcd_reg;
  logic [NUM_BITS-1:0]       bin_reg;
  logic [CW-1:0]             count;

  logic [15+NUM_BITS:0]      shifted;
  logic [15:0]               bcd_adjusted;
  logic [CW-1:0]             count_inc;
  logic                      in_malformed;

  // A digit nibble holding 10..15 is not valid BCD
  function automatic logic nibble_bad(input logic [3:0] n);
    return n > 4'd9;
  endfunction

  // Undo the doubling of the lower digit: a nibble at 8 or above carried a 10 in
  function automatic logic [3:0] nibble_adjust(input logic [3:0] n);
    return (n >= 4'd8) ? (n - 4'd3) : n;
  endfunction

  assign bcd_in_ready = (state == IDLE) && !rst;

  // Datapath helpers: combined right shift, per-nibble adjust, malformed-input detect
  always_comb begin
    shifted      = {bcd_reg, bin_reg} >> 1;
    count_inc    = count + 1'b1;
    bcd_adjusted = {nibble_adjust(bcd_reg[15:12]), nibble_adjust(bcd_reg[11:8]),
                    nibble_adjust(bcd_reg[7:4]),   nibble_adjust(bcd_reg[3:0])};
    in_malformed = nibble_bad(bcd_in[15:12]) || nibble_bad(bcd_in[11:8]) ||
                   nibble_bad(bcd_in[7:4])   || nibble_bad(bcd_in[3:0]);
  end

  // Control FSM with registered result, error flag and valid
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      bcd_reg          <= '0;
      bin_reg          <= '0;
      count            <= '0;
      binary_out       <= '0;
      binary_out_valid <= 1'b0;
      bcd_error        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bcd_in_valid && bcd_in_ready) begin
            bcd_reg <= bcd_in;
            bin_reg <= '0;
            count   <= '0;
            if (in_malformed) begin
              binary_out       <= '0;
              bcd_error        <= 1'b1;
              binary_out_valid <= 1'b1;
              state            <= DONE;
            end else begin
              bcd_error <= 1'b0;
              state     <= SHIFT;
            end
          end
        end
        SHIFT: begin
          {bcd_reg, bin_reg} <= shifted;
          count              <= count_inc;
          if (count_inc == LAST_COUNT) begin
            binary_out       <= shifted[NUM_BITS-1:0];
            binary_out_valid <= 1'b1;
            state            <= DONE;
          end else begin
            state <= ADJUST;
          end
        end
        ADJUST: begin
          bcd_reg <= bcd_adjusted;
          state   <= SHIFT;
        end
        DONE: begin
          if (binary_out_ready) begin
            binary_out_valid <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
